// File: rtl/sblk_ctrl_pkg.sv
// sblk_ctrl_pkg: shared arbiter state type and default burst/issue-gap lengths
package sblk_ctrl_pkg;
  typedef enum logic {IDLE, BURST} arb_state_e;
  localparam int ISSUE_GAP_DEF = 2;
  localparam int BURST_LEN_DEF = 8;
endpackage

// File: rtl/sblk_row_ctrl_rr_arb.sv
// rr_arb: round-robin one-hot grant over req_i (ptr = highest-priority row, upd_i/upd_idx_i move it past upd_idx_i)
module rr_arb #(
  parameter int N_ROW = 4,
  parameter int WID_ROWID = $clog2(N_ROW)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_ROW-1:0]     req_i,
  input  logic                 upd_i,
  input  logic [WID_ROWID-1:0] upd_idx_i,
  output logic [N_ROW-1:0]     gnt_o
);
  logic [WID_ROWID-1:0] ptr_q, idx;
  logic found;
  int sum;
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx = '0;
    sum = 0;
    for (int i = 0; i < N_ROW; i++) begin
      sum = int'(ptr_q) + i;
      idx = WID_ROWID'(sum >= N_ROW ? sum - N_ROW : sum);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) ptr_q <= '0;
    else if (upd_i) ptr_q <= (upd_idx_i == WID_ROWID'(N_ROW-1)) ? '0 : upd_idx_i + WID_ROWID'(1);
endmodule

// File: rtl/sblk_row_ctrl.sv
// sblk_row_ctrl: per-row instruction dispatch gated by status_sblk plus round-robin burst sharing of the activation stream (clk_l, sync rst)
module sblk_row_ctrl
  import sblk_ctrl_pkg::*;
#(
  parameter int N_ROW     = 4,
  parameter int WID_ACT   = 16,
  parameter int WID_INST  = 14,
  parameter int WID_ROWID = $clog2(N_ROW),
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int ISSUE_GAP = ISSUE_GAP_DEF
) (
  input  logic                          clk_l,
  input  logic                          rst,
  input  logic [WID_INST-1:0]           inst_in_data,
  input  logic [WID_ROWID-1:0]          inst_in_row,
  input  logic                          inst_in_vld,
  output logic                          inst_in_rdy,
  output logic [WID_INST*N_ROW-1:0]     inst_data,
  output logic [N_ROW-1:0]              inst_en,
  input  logic [N_ROW-1:0]              status_sblk,
  input  logic [2*WID_ACT-1:0]          act_src_data,
  input  logic                          act_src_vld,
  output logic                          act_src_rdy,
  output logic [WID_ROWID-1:0]          act_src_row,
  output logic [2*WID_ACT*N_ROW-1:0]    act_data_in,
  output logic [N_ROW-1:0]              act_data_in_vld,
  input  logic [N_ROW-1:0]              act_data_in_req,
  output logic                          busy
);
  localparam int GW = $clog2(ISSUE_GAP + 2);
  localparam int CW = $clog2(BURST_LEN);
  logic [N_ROW-1:0] pend;
  assign inst_in_rdy = ~rst & ~pend[inst_in_row];
  for (genvar r = 0; r < N_ROW; r++) begin : g_row
    logic pend_q, en_q, issue, acc;
    logic [WID_INST-1:0] lat_q, data_q;
    logic [GW-1:0] gap_q;
    assign issue = pend_q & ~status_sblk[r] & (gap_q == '0);
    assign acc = inst_in_vld & inst_in_rdy & (inst_in_row == WID_ROWID'(r));
    assign pend[r] = pend_q;
    assign inst_en[r] = en_q;
    assign inst_data[r*WID_INST +: WID_INST] = data_q;
    always_ff @(posedge clk_l)
      if (rst) begin
        pend_q <= 1'b0;
        en_q <= 1'b0;
        lat_q <= '0;
        data_q <= '0;
        gap_q <= '0;
      end else begin
        en_q <= issue;
        gap_q <= issue ? GW'(ISSUE_GAP) : (gap_q != '0 ? gap_q - GW'(1) : gap_q);
        if (issue) begin
          pend_q <= 1'b0;
          data_q <= lat_q;
        end else if (acc) begin
          pend_q <= 1'b1;
          lat_q <= inst_in_data;
        end
      end
  end
  arb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WID_ROWID-1:0] row_q, row_d, gnt_idx;
  logic [N_ROW-1:0] gnt, vld_q;
  logic [N_ROW-1:0][2*WID_ACT-1:0] act_q;
  logic beat, upd;
  rr_arb #(.N_ROW(N_ROW), .WID_ROWID(WID_ROWID)) u_arb (
    .clk(clk_l), .rst(rst), .req_i(act_data_in_req), .upd_i(upd), .upd_idx_i(row_q), .gnt_o(gnt)
  );
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_ROW; i++) if (gnt[i]) gnt_idx = WID_ROWID'(i);
  end
  assign act_src_rdy = state_q == BURST;
  assign beat = act_src_vld & act_src_rdy;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    row_d = row_q;
    upd = 1'b0;
    if (state_q == IDLE) begin
      if (|act_data_in_req) begin
        state_d = BURST;
        cnt_d = '0;
        row_d = gnt_idx;
      end
    end else if (beat) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(BURST_LEN-1)) begin
        state_d = IDLE;
        upd = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_l)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      row_q <= '0;
      vld_q <= '0;
      act_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      vld_q <= beat ? (N_ROW'(1) << row_q) : '0;
      if (beat) act_q[row_q] <= act_src_data;
    end
  assign act_src_row = row_q;
  assign act_data_in = act_q;
  assign act_data_in_vld = vld_q;
  assign busy = |pend | act_src_rdy;
endmodule

// File: tb/tb_sblk_row_ctrl.sv
// tb_sblk_row_ctrl: scoreboard bench for dispatch gating, issue gap, round-robin bursts, stalls and mid-burst reset
module tb_sblk_row_ctrl;
  localparam int BL = 8;
  logic clk_l = 1'b0, rst = 1'b1;
  logic [13:0] inst_in_data;
  logic [1:0] inst_in_row;
  logic inst_in_vld, inst_in_rdy;
  logic [55:0] inst_data;
  logic [3:0] inst_en, status_sblk;
  logic [31:0] act_src_data;
  logic act_src_vld, act_src_rdy;
  logic [1:0] act_src_row;
  logic [127:0] act_data_in;
  logic [3:0] act_data_in_vld, act_data_in_req;
  logic busy;
  typedef struct packed {logic [1:0] row; logic [31:0] data;} act_t;
  typedef struct packed {logic [1:0] row; logic [13:0] data;} ins_t;
  act_t aq[$];
  ins_t iq[$];
  act_t a;
  ins_t b;
  int vecs = 0, errs = 0;
  int order[4];
  sblk_row_ctrl dut (
    .clk_l(clk_l), .rst(rst), .inst_in_data(inst_in_data), .inst_in_row(inst_in_row),
    .inst_in_vld(inst_in_vld), .inst_in_rdy(inst_in_rdy), .inst_data(inst_data), .inst_en(inst_en),
    .status_sblk(status_sblk), .act_src_data(act_src_data), .act_src_vld(act_src_vld),
    .act_src_rdy(act_src_rdy), .act_src_row(act_src_row), .act_data_in(act_data_in),
    .act_data_in_vld(act_data_in_vld), .act_data_in_req(act_data_in_req), .busy(busy)
  );
  always #5 clk_l = ~clk_l;
  always @(negedge clk_l) begin
    if (act_data_in_vld != 4'b0) begin
      vecs++;
      if (aq.size() == 0) begin
        errs++;
        $display("FAIL act_extra: vld=%b data=%h, no beat expected", act_data_in_vld, act_data_in);
      end else begin
        a = aq.pop_front();
        if (act_data_in_vld !== (4'b1 << a.row) || act_data_in[a.row*32 +: 32] !== a.data || act_src_row !== a.row) begin
          errs++;
          $display("FAIL act_beat: vld=%b data=%h row=%0d, want vld=%b data=%h row=%0d",
                   act_data_in_vld, act_data_in[a.row*32 +: 32], act_src_row, 4'b1 << a.row, a.data, a.row);
        end
      end
    end
    if (inst_en != 4'b0) begin
      vecs++;
      if (iq.size() == 0) begin
        errs++;
        $display("FAIL inst_extra: en=%b, no issue expected", inst_en);
      end else begin
        b = iq.pop_front();
        if (inst_en !== (4'b1 << b.row) || inst_data[b.row*14 +: 14] !== b.data) begin
          errs++;
          $display("FAIL inst_issue: en=%b data=%h, want en=%b data=%h", inst_en, inst_data[b.row*14 +: 14], 4'b1 << b.row, b.data);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk_l);
    #1;
  endtask
  task automatic apply_reset();
    rst = 1'b1;
    inst_in_vld = 1'b0;
    inst_in_data = '0;
    inst_in_row = '0;
    status_sblk = '0;
    act_src_vld = 1'b0;
    act_src_data = '0;
    act_data_in_req = '0;
    repeat (2) tick();
    aq.delete();
    iq.delete();
    rst = 1'b0;
  endtask
  task automatic wait_rdy(input int max);
    int n = 0;
    while (!act_src_rdy && n < max) begin
      tick();
      n++;
    end
    vecs++;
    if (act_src_rdy !== 1'b1) begin
      errs++;
      $display("FAIL grant_timeout: act_src_rdy=%b after %0d cycles, want 1", act_src_rdy, n);
    end
  endtask
  task automatic drain(input string nm);
    int n = 0;
    while (aq.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    vecs++;
    if (aq.size() != 0) begin
      errs++;
      $display("FAIL %s_drain: %0d beats outstanding, want 0", nm, aq.size());
    end
  endtask
  task automatic run_src(input int beats, input bit toggle, input int drop_at, input logic [31:0] base, input int max_cyc);
    int cnt = 0, cyc = 0, low = 0;
    bit hs, seen_hi = 1'b0;
    while (cnt < beats && cyc < max_cyc) begin
      act_src_vld = toggle ? (cyc % 2 == 0) : 1'b1;
      act_src_data = base + cnt;
      @(negedge clk_l);
      hs = act_src_vld & act_src_rdy;
      if (act_src_rdy) begin
        if (seen_hi && low != 0) begin
          vecs++;
          if (low != 1) begin
            errs++;
            $display("FAIL burst_gap: rdy low %0d cycles between bursts, want 1", low);
          end
        end
        seen_hi = 1'b1;
        low = 0;
      end else if (seen_hi) low++;
      if (hs) aq.push_back({2'(order[cnt/BL]), base + cnt});
      tick();
      if (hs) begin
        cnt++;
        if (cnt == drop_at) act_data_in_req = '0;
      end
      cyc++;
    end
    vecs++;
    if (cnt != beats) begin
      errs++;
      $display("FAIL src_timeout: %0d beats accepted, want %0d", cnt, beats);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_in_data = 14'($urandom);
      inst_in_row = 2'($urandom);
      inst_in_vld = 1'($urandom);
      status_sblk = 4'($urandom);
      act_src_data = $urandom;
      act_src_vld = 1'($urandom);
      act_data_in_req = 4'($urandom);
      tick();
      vecs++;
      if ({inst_in_rdy, inst_data, inst_en, act_src_rdy, act_src_row, act_data_in, act_data_in_vld, busy} !== '0) begin
        errs++;
        $display("FAIL reset_outputs c%0d: in_rdy=%b en=%b idata=%h src_rdy=%b row=%0d vld=%b adata=%h busy=%b, want all 0",
                 i, inst_in_rdy, inst_en, inst_data, act_src_rdy, act_src_row, act_data_in_vld, act_data_in, busy);
      end
    end
    apply_reset();
    act_data_in_req = 4'b1111;
    wait_rdy(5);
    vecs++;
    if (act_src_row !== 2'd0) begin
      errs++;
      $display("FAIL reset_first_grant: row=%0d, want 0", act_src_row);
    end
    apply_reset();
  endtask
  task automatic test_dispatch();
    status_sblk = 4'b0100;
    inst_in_row = 2'd2;
    inst_in_data = 14'h1A5;
    inst_in_vld = 1'b1;
    #1;
    vecs++;
    if (inst_in_rdy !== 1'b1) begin errs++; $display("FAIL disp_rdy_empty: rdy=%b, want 1", inst_in_rdy); end
    iq.push_back({2'd2, 14'h1A5});
    tick();
    inst_in_data = 14'h2B6;
    for (int i = 0; i < 10; i++) begin
      #1;
      vecs++;
      if (inst_in_rdy !== 1'b0 || inst_en !== 4'b0 || busy !== 1'b1) begin
        errs++;
        $display("FAIL disp_gated c%0d: rdy=%b en=%b busy=%b, want 0 0000 1", i, inst_in_rdy, inst_en, busy);
      end
      tick();
    end
    status_sblk = 4'b0000;
    #1;
    vecs++;
    if (inst_in_rdy !== 1'b0) begin errs++; $display("FAIL disp_refill_early: rdy=%b, want 0", inst_in_rdy); end
    tick();
    vecs++;
    if (inst_en !== 4'b0100 || inst_data[28 +: 14] !== 14'h1A5 || inst_in_rdy !== 1'b1) begin
      errs++;
      $display("FAIL disp_issue: en=%b data=%h rdy=%b, want 0100 1a5 1", inst_en, inst_data[28 +: 14], inst_in_rdy);
    end
    inst_in_vld = 1'b0;
    tick();
    vecs++;
    if (inst_en !== 4'b0 || inst_data[28 +: 14] !== 14'h1A5 || busy !== 1'b0) begin
      errs++;
      $display("FAIL disp_after: en=%b data=%h busy=%b, want 0000 1a5 0", inst_en, inst_data[28 +: 14], busy);
    end
  endtask
  task automatic test_issue_gap();
    status_sblk = 4'b0000;
    inst_in_row = 2'd1;
    inst_in_data = 14'h055;
    inst_in_vld = 1'b1;
    iq.push_back({2'd1, 14'h055});
    tick();
    inst_in_vld = 1'b0;
    tick();
    vecs++;
    if (inst_en !== 4'b0010) begin errs++; $display("FAIL gap_first_issue: en=%b, want 0010", inst_en); end
    inst_in_data = 14'h3C3;
    inst_in_vld = 1'b1;
    #1;
    vecs++;
    if (inst_in_rdy !== 1'b1) begin errs++; $display("FAIL gap_refill_rdy: rdy=%b, want 1", inst_in_rdy); end
    iq.push_back({2'd1, 14'h3C3});
    tick();
    inst_in_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) status_sblk = 4'b0010;
      vecs++;
      if (inst_en !== 4'b0) begin errs++; $display("FAIL gap_double_issue c%0d: en=%b, want 0000", i, inst_en); end
      tick();
    end
    status_sblk = 4'b0000;
    tick();
    vecs++;
    if (inst_en !== 4'b0010) begin errs++; $display("FAIL gap_second_issue: en=%b, want 0010", inst_en); end
    tick();
  endtask
  task automatic test_round_robin();
    apply_reset();
    order = '{0, 1, 3, 0};
    act_data_in_req = 4'b1011;
    run_src(4*BL, 1'b0, 4*BL, 32'hA000, 400);
    act_src_vld = 1'b0;
    drain("rr");
  endtask
  task automatic test_stall();
    apply_reset();
    order = '{0, 0, 0, 0};
    act_data_in_req = 4'b0001;
    run_src(BL, 1'b1, 3, 32'h0, 100);
    act_src_vld = 1'b0;
    drain("stall");
    vecs++;
    if (act_src_rdy !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL stall_idle: rdy=%b busy=%b, want 0 0", act_src_rdy, busy);
    end
  endtask
  task automatic test_mid_reset();
    apply_reset();
    order = '{2, 2, 2, 2};
    act_data_in_req = 4'b0100;
    run_src(5, 1'b0, 99, 32'h5500, 50);
    act_src_vld = 1'b1;
    rst = 1'b1;
    tick();
    vecs++;
    if (act_src_rdy !== 1'b0 || act_data_in_vld !== 4'b0 || aq.size() != 0) begin
      errs++;
      $display("FAIL midrst_abort: rdy=%b vld=%b pending=%0d, want 0 0000 0", act_src_rdy, act_data_in_vld, aq.size());
    end
    tick();
    rst = 1'b0;
    act_src_vld = 1'b0;
    act_data_in_req = 4'b1111;
    wait_rdy(5);
    vecs++;
    if (act_src_row !== 2'd0) begin errs++; $display("FAIL midrst_restart: row=%0d, want 0", act_src_row); end
    apply_reset();
  endtask
  initial begin
    test_reset();
    test_dispatch();
    test_issue_gap();
    test_round_robin();
    test_stall();
    test_mid_reset();
    vecs++;
    if (iq.size() != 0) begin errs++; $display("FAIL inst_outstanding: %0d issues missing, want 0", iq.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/sblk_row_ctrl.md
Name: sblk_row_ctrl

Overview:
- Sequencer for one superblock row of N_ROW superblocks; sits between the layer controller and the row.
- Dispatches per-row instructions, gated by each superblock's busy status.
- Shares a single upstream activation stream among the rows' act_data_in_req lines with a round-robin, fixed-length-burst arbiter.
- Runs entirely in the clk_l domain.

Parameters:
- N_ROW, 4, superblocks in the row
- WID_ACT, 16, activation word width (bus is 2*WID_ACT)
- WID_INST, 14, instruction width per superblock
- WID_ROWID, $clog2(N_ROW), row index width
- BURST_LEN, 8, activation beats per grant (≥2)
- ISSUE_GAP, 2, cycles after an issue during which status_sblk of that row is ignored

Ports:
- clk_l  in  1  clock
- rst  in  1  reset; synchronous, active-high
- inst_in_data  in  WID_INST  instruction from controller
- inst_in_row  in  WID_ROWID  destination superblock
- inst_in_vld  in  1  instruction valid
- inst_in_rdy  out  1  instruction accepted when vld&rdy
- inst_data  out  WID_INST*N_ROW  per-row instruction, slice r = row r
- inst_en  out  N_ROW  one-cycle issue pulse per row
- status_sblk  in  N_ROW  1 = superblock busy
- act_src_data  in  2*WID_ACT  shared activation stream
- act_src_vld  in  1  stream valid
- act_src_rdy  out  1  stream ready
- act_src_row  out  WID_ROWID  row currently granted (upstream fetch selects data by it)
- act_data_in  out  2*WID_ACT*N_ROW  per-row activation data
- act_data_in_vld  out  N_ROW  per-row beat valid
- act_data_in_req  in  N_ROW  level: row buffer can absorb ≥BURST_LEN beats
- busy  out  1  any pending instruction or active burst

Behaviour:
Reset:
- Every output is 0; pend[], gap counters, burst counter and grant are cleared.
- RR pointer resets so that row 0 has highest priority.
- A reset asserted mid-burst aborts the burst with no further act_data_in_vld.

Dispatch:
- Each row has a one-entry pending register pend[r] holding the instruction.
- inst_in_rdy = ~pend[inst_in_row], combinational. On accept, pend[r] is set and the value is latched.
- Issue condition for row r: pend[r] & ~status_sblk[r] & gap[r]==0.
- On issue, in the next cycle:
  - inst_en[r]=1 for exactly one cycle;
  - slice r of inst_data = latched value, held until the next issue to that row;
  - pend[r] clears;
  - gap[r] loads ISSUE_GAP and decrements to 0; status_sblk[r] is ignored while gap[r]≠0 and while pend[r] is clear.
- Rows issue independently; several inst_en bits may pulse in the same cycle.
- No refill in the same cycle as an issue: inst_in_rdy for row r stays 0 until pend[r] has cleared.

Activation arbiter FSM:
- IDLE:
  - If |act_data_in_req, round-robin picks g, starting at (last grant+1) mod N_ROW.
  - act_src_row<=g, cnt<=0, go to BURST.
  - act_src_rdy=0 in IDLE.
- BURST:
  - act_src_rdy=1.
  - Each beat (act_src_vld&rdy): next cycle, act_data_in slice g = act_src_data and act_data_in_vld[g]=1 for one cycle. Latency 1 cycle; other slices hold their values.
  - cnt++. On the beat with cnt==BURST_LEN-1, go to IDLE and update the RR pointer to g.
- Dropping act_data_in_req[g] mid-burst does not shorten the burst.
- act_src_vld gaps stall the burst without timeout.
- Minimum one IDLE cycle between bursts.
- act_src_row is stable for the whole burst.

Status:
- busy = |pend | (state==BURST), combinational.

Decomposition:
- Package sblk_ctrl_pkg holds the arbiter state enum (IDLE, BURST) and the ISSUE_GAP/BURST_LEN defaults.
- One sub-module, rr_arb: an N_ROW-wide round-robin arbiter with a one-hot grant and a pointer-update strobe.
- Dispatch logic is a generate-per-row in the top module.

Test Plan:
- Reset check: hold rst 3 cycles with random inputs -> all outputs 0. First req=4'b1111 -> grant row 0.
- Dispatch gating: inst 0x1A5 to row 2 while status_sblk[2]=1 for 10 cycles -> no inst_en. Release status -> inst_en=4'b0100 one cycle later, inst_data[2]=0x1A5. A second inst to row 2 is refused (inst_in_rdy=0) until the issue has happened.
- Issue gap: status_sblk[1] rises 2 cycles after the issue and a second inst is pending -> no double issue. Next inst_en[1] only after status falls.
- Round-robin fairness: req=4'b1011 held, BURST_LEN=8, continuous act_src_vld -> grant order 0,1,3,0. Each grant gives exactly 8 act_data_in_vld pulses on that row. act_src_rdy is low one cycle between bursts.
- Stream stalls: act_src_vld toggling 1010…, req dropped at beat 3 -> burst still delivers 8 beats in order, data matching the source sequence 0..7.
- Mid-burst reset: rst at beat 5 -> act_src_rdy=0 and act_data_in_vld=0 next cycle. After release, arbitration restarts from row 0.
